// File: rtl/rgmii_rx_frame_decode.sv
// rtl/rgmii_rx_frame_decode.sv - RGMII receive frame decoder; in-band link status optional via RGMII_RX_INBAND_STATUS_EN
module rgmii_rx_frame_decode #(
    parameter int MAX_PREAMBLE = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rx_q1,
    input  logic [4:0] rx_q2,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       stat_rx_frame,
    output logic       stat_rx_bad_frame,
    output logic       stat_rx_err_preamble,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_full_duplex
);

    localparam int CNT_W = $clog2(MAX_PREAMBLE + 2);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // input stage
    logic [7:0]       byte_q;
    logic             dv_q;
    logic             er_q;
    logic             stage_vld_q;

    // decoder state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             flag_q, flag_d;
    logic             armed_q, armed_d;

    // registered outputs
    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             tuser_q, tuser_d;
    logic             frame_q, frame_d;
    logic             bad_q, bad_d;
    logic             pre_q, pre_d;

    // Capture the DDR pair: data nibbles rise-first, RX_CTL rise is DV, rise^fall is ER
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q      <= 8'h00;
            dv_q        <= 1'b0;
            er_q        <= 1'b0;
            stage_vld_q <= 1'b0;
        end else begin
            byte_q      <= {rx_q2[3:0], rx_q1[3:0]};
            dv_q        <= rx_q1[4];
            er_q        <= rx_q1[4] ^ rx_q2[4];
            stage_vld_q <= 1'b1;
        end
    end

    // Next-state and output decode; armed_q keeps a frame cut by reset from being picked up mid-way
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        flag_d     = flag_q;
        armed_d    = armed_q | (stage_vld_q & ~dv_q);
        tdata_d    = hold_q;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
        frame_d    = 1'b0;
        bad_d      = 1'b0;
        pre_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hold_vld_d = 1'b0;
                flag_d     = 1'b0;
                if (armed_q && dv_q) begin
                    if (er_q) begin
                        state_d = ST_DROP;
                        pre_d   = 1'b1;
                    end else if (byte_q == 8'h55) begin
                        state_d = ST_PREAMBLE;
                        cnt_d   = CNT_W'(1);
                    end else if (byte_q == 8'hD5) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_DROP;
                        pre_d   = 1'b1;
                    end
                end else if (!dv_q && er_q) begin
                    state_d = ST_DROP;
                    pre_d   = 1'b1;
                end
            end

            ST_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                    pre_d   = 1'b1;
                end else if (er_q) begin
                    state_d = ST_DROP;
                    pre_d   = 1'b1;
                end else if (byte_q == 8'h55) begin
                    if (cnt_q >= CNT_W'(MAX_PREAMBLE)) begin
                        state_d = ST_DROP;
                        pre_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (byte_q == 8'hD5) begin
                    state_d    = ST_DATA;
                    hold_vld_d = 1'b0;
                    flag_d     = 1'b0;
                end else begin
                    state_d = ST_DROP;
                    pre_d   = 1'b1;
                end
            end

            ST_DATA: begin
                if (dv_q) begin
                    hold_d     = byte_q;
                    hold_vld_d = 1'b1;
                    flag_d     = flag_q | er_q;
                    tvalid_d   = hold_vld_q;
                end else begin
                    state_d    = ST_IDLE;
                    hold_vld_d = 1'b0;
                    if (hold_vld_q) begin
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tuser_d  = flag_q | er_q;
                        frame_d  = ~(flag_q | er_q);
                        bad_d    = flag_q | er_q;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end

            ST_DROP: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Decoder state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            flag_q     <= 1'b0;
            armed_q    <= 1'b0;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            frame_q    <= 1'b0;
            bad_q      <= 1'b0;
            pre_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            flag_q     <= flag_d;
            armed_q    <= armed_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            frame_q    <= frame_d;
            bad_q      <= bad_d;
            pre_q      <= pre_d;
        end
    end

    assign m_axis_tdata         = tdata_q;
    assign m_axis_tvalid        = tvalid_q;
    assign m_axis_tlast         = tlast_q;
    assign m_axis_tuser         = tuser_q;
    assign stat_rx_frame        = frame_q;
    assign stat_rx_bad_frame    = bad_q;
    assign stat_rx_err_preamble = pre_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
    logic       link_up_q;
    logic [1:0] link_speed_q;
    logic       link_fd_q;

    // Inter-frame idle carries link status on RXD; frozen while a frame is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_up_q    <= 1'b0;
            link_speed_q <= 2'b00;
            link_fd_q    <= 1'b0;
        end else if (!dv_q && !er_q) begin
            link_up_q    <= byte_q[0];
            link_speed_q <= byte_q[2:1];
            link_fd_q    <= byte_q[3];
        end
    end

    assign link_up          = link_up_q;
    assign link_speed       = link_speed_q;
    assign link_full_duplex = link_fd_q;
`else
    assign link_up          = 1'b0;
    assign link_speed       = 2'b00;
    assign link_full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_frame_decode.sv
// tb/tb_rgmii_rx_frame_decode.sv - self-checking bench for rgmii_rx_frame_decode
module tb_rgmii_rx_frame_decode;

    localparam int MAXP = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rx_q1 = 5'h0D;
    logic [4:0] rx_q2 = 5'h00;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic       stat_rx_frame, stat_rx_bad_frame, stat_rx_err_preamble;
    logic       link_up, link_full_duplex;
    logic [1:0] link_speed;

    always #5 clk = ~clk;

    rgmii_rx_frame_decode #(.MAX_PREAMBLE(MAXP)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rx_q1                (rx_q1),
        .rx_q2                (rx_q2),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tuser         (m_axis_tuser),
        .stat_rx_frame        (stat_rx_frame),
        .stat_rx_bad_frame    (stat_rx_bad_frame),
        .stat_rx_err_preamble (stat_rx_err_preamble),
        .link_up              (link_up),
        .link_speed           (link_speed),
        .link_full_duplex     (link_full_duplex)
    );

    typedef struct {
        logic [7:0] b;
        bit         er;
    } rxb_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    rxb_t        cur[$];
    logic [9:0]  exp_q[$];
    logic [9:0]  act_q[$];
    int unsigned sent_edge[$];
    int unsigned beat_edge[$];
    int          exp_good = 0, exp_bad = 0, exp_pre = 0;
    int          act_good = 0, act_bad = 0, act_pre = 0;
    logic        prev_last = 1'b0;
    logic [3:0]  idle_nib = 4'hD;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_last = 1'b0;
        end else begin
            if (m_axis_tvalid) begin
                act_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
                beat_edge.push_back(cyc);
                chk("frame_gap", 32'(prev_last), 32'd0);
            end else begin
                chk("idle_tlast_tuser", 32'({m_axis_tlast, m_axis_tuser}), 32'd0);
            end
            if (stat_rx_frame) begin
                act_good++;
                chk("frame_pulse_beat", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser}), 32'd6);
            end
            if (stat_rx_bad_frame) begin
                act_bad++;
                if (m_axis_tvalid) chk("bad_pulse_beat", 32'({m_axis_tlast, m_axis_tuser}), 32'd3);
            end
            if (stat_rx_err_preamble) act_pre++;
            prev_last = m_axis_tvalid & m_axis_tlast;
        end
    end

    task automatic drive(input logic [7:0] b, input bit dv, input bit er);
        @(negedge clk);
        rx_q1 = {dv, b[3:0]};
        rx_q2 = {dv ^ er, b[7:4]};
    endtask

    task automatic drive_idle(input int n);
        repeat (n) drive({4'h0, idle_nib}, 1'b0, 1'b0);
    endtask

    task automatic push_b(input logic [7:0] b, input bit er);
        rxb_t x;
        x.b = b;
        x.er = er;
        cur.push_back(x);
    endtask

    // npre x 0x55, sfd, payload 1..nbytes, er on payload value er_at (0 = none)
    task automatic build(input int npre, input logic [7:0] sfd, input int nbytes, input int er_at);
        cur.delete();
        repeat (npre) push_b(8'h55, 1'b0);
        push_b(sfd, 1'b0);
        for (int i = 1; i <= nbytes; i++) push_b(8'(i), i == er_at);
    endtask

    task automatic send_cur(input int gap);
        foreach (cur[i]) begin
            drive(cur[i].b, 1'b1, cur[i].er);
            sent_edge.push_back(cyc + 1);
        end
        drive_idle(gap);
    endtask

    // Frame accepted iff it opens with at most MAXP clean 0x55 then a clean 0xD5
    task automatic model_cur();
        int  i = 0;
        int  p;
        bit  u = 1'b0;
        while (i < cur.size() && cur[i].b == 8'h55 && !cur[i].er) i++;
        if (i >= cur.size() || i > MAXP || cur[i].b != 8'hD5 || cur[i].er) begin
            exp_pre++;
            return;
        end
        p = i + 1;
        if (p == cur.size()) begin
            exp_bad++;
            return;
        end
        for (int j = p; j < cur.size(); j++) u |= cur[j].er;
        for (int j = p; j < cur.size(); j++)
            exp_q.push_back({cur[j].b, j == cur.size() - 1, (j == cur.size() - 1) ? u : 1'b0});
        if (u) exp_bad++;
        else   exp_good++;
    endtask

    task automatic clear_all();
        exp_q.delete(); act_q.delete(); sent_edge.delete(); beat_edge.delete();
        exp_good = 0; exp_bad = 0; exp_pre = 0;
        act_good = 0; act_bad = 0; act_pre = 0;
    endtask

    task automatic compare(input string tag);
        chk({tag, "_beats"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk({tag, "_beat"}, 32'(act_q[i]), 32'(exp_q[i]));
        chk({tag, "_good"}, 32'(act_good), 32'(exp_good));
        chk({tag, "_bad"}, 32'(act_bad), 32'(exp_bad));
        chk({tag, "_pre"}, 32'(act_pre), 32'(exp_pre));
        clear_all();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
        chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'd0);
        chk({tag, "_tuser"}, 32'(m_axis_tuser), 32'd0);
        chk({tag, "_tdata"}, 32'(m_axis_tdata), 32'd0);
        chk({tag, "_stats"}, 32'({stat_rx_frame, stat_rx_bad_frame, stat_rx_err_preamble}), 32'd0);
        chk({tag, "_link"}, 32'({link_up, link_speed, link_full_duplex}), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lasts;
        int n;
        // reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        drive_idle(4);

        // in-band status from idle nibble 0xD
`ifdef RGMII_RX_INBAND_STATUS_EN
        chk("link_up", 32'(link_up), 32'd1);
        chk("link_speed", 32'(link_speed), 32'd2);
        chk("link_fd", 32'(link_full_duplex), 32'd1);
`else
        chk("link_up", 32'(link_up), 32'd0);
        chk("link_speed", 32'(link_speed), 32'd0);
        chk("link_fd", 32'(link_full_duplex), 32'd0);
`endif

        // nominal 64-byte frame with latency check
        build(7, 8'hD5, 64, 0);
        send_cur(1);
        model_cur();
        drive_idle(4);
        chk("lat_beats", 32'(beat_edge.size()), 32'd64);
        if (beat_edge.size() >= 64 && sent_edge.size() >= 72) begin
            chk("lat_first", beat_edge[0] - sent_edge[8], 32'd2);
            chk("lat_last", beat_edge[63] - sent_edge[71], 32'd2);
        end
        compare("nominal");

        // er on payload byte 10
        build(7, 8'hD5, 64, 10);
        send_cur(1); model_cur(); drive_idle(4);
        compare("er_frame");

        // bad preamble byte
        cur.delete();
        push_b(8'h55, 0); push_b(8'h55, 0); push_b(8'hA5, 0);
        repeat (5) push_b(8'($urandom), 0);
        send_cur(1); model_cur(); drive_idle(4);
        compare("bad_pre");

        // preamble too long, then exactly at the limit
        build(16, 8'hD5, 8, 0);
        send_cur(1); model_cur(); drive_idle(4);
        compare("pre16");
        build(15, 8'hD5, 8, 0);
        send_cur(1); model_cur(); drive_idle(4);
        compare("pre15");

        // empty after SFD
        build(1, 8'hD5, 0, 0);
        send_cur(1); model_cur(); drive_idle(4);
        compare("empty");

        // back-to-back with one idle cycle
        build(7, 8'hD5, 20, 0);
        send_cur(1); model_cur();
        build(3, 8'hD5, 9, 0);
        send_cur(1); model_cur(); drive_idle(4);
        compare("b2b");

        // reset at payload byte 20
        build(7, 8'hD5, 64, 0);
        foreach (cur[i]) begin
            drive(cur[i].b, 1'b1, cur[i].er);
            if (i == 8 + 19) begin
                #2;
                chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
                rst = 1'b1;
                #1;
                check_outputs_zero("mid_rst");
            end
            if (i == 8 + 20) rst = 1'b0;
        end
        drive_idle(4);
        lasts = 0;
        foreach (act_q[i]) lasts += int'(act_q[i][1]);
        chk("rst_no_tlast", 32'(lasts), 32'd0);
        chk("rst_no_stats", 32'(act_good + act_bad + act_pre), 32'd0);
        clear_all();
        build(7, 8'hD5, 64, 0);
        send_cur(1); model_cur(); drive_idle(4);
        compare("post_rst");

        // randomized frames
        repeat (40) begin
            cur.delete();
            n = $urandom_range(0, 17);
            repeat (n) push_b(8'h55, $urandom_range(0, 39) == 0);
            push_b(($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hD5, $urandom_range(0, 29) == 0);
            n = $urandom_range(0, 16);
            repeat (n) push_b(8'($urandom), $urandom_range(0, 19) == 0);
            send_cur($urandom_range(1, 3));
            model_cur();
        end
        drive_idle(4);
        compare("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
